match_send_memory: RTL
======================

// Module: match_send_memory
// PURPOSE
//  Transmit end of the match-record link. Buffers 44-bit match records produced by the
//  match calculator and drives them onto the link. Idle is signalled by tag bits [43:40]=0,
//  so the receiving memory writes only words with a non-zero tag.
//  Single-clock: sits in the proc_clk domain ahead of the cross-board/cross-domain link.
// PARAMETERS
//  DEPTH    64  buffer entries; power of two, 4..1024
//  AW       6   address width = log2(DEPTH)
//  CNT_W    16  width of the saturating diagnostic counters
// PORTS
//  proc_clk     in   1     sole clock; all logic on posedge
//  reset        in   1     synchronous, active-high
//  match_in     in   44    match record; [43:40] tag, [39:0] payload
//  match_wr     in   1     write strobe for match_in
//  ready        out  1     buffer not full (registered)
//  link_en      in   1     downstream accepts a word this cycle
//  matchout     out  44    link word; 44'h0 when idle
//  valid        out  1     matchout carries a record (equals |matchout[43:40])
//  fill         out  AW+1  current occupancy, 0..DEPTH
//  dropped_cnt  out  CNT_W writes rejected (zero tag or full); saturates at all-ones
//  overflow     out  1     sticky: set on any write rejected because buffer was full
// BEHAVIOUR
//  - Reset: pointers=0, fill=0, ready=1, matchout=0, valid=0, dropped_cnt=0, overflow=0.
//    Reset mid-stream discards all buffered words; no partial word is emitted afterwards.
//  - Write accept: match_wr && match_in[43:40]!=0 && fill<DEPTH (fill at cycle start).
//    A zero-tag write is never stored (it would be indistinguishable from idle);
//    increment dropped_cnt only. A write while full: increment dropped_cnt, set overflow.
//  - Pop: link_en && fill!=0 (fill at cycle start). The popped word is registered onto
//    matchout next cycle with valid=1. Cycles without a pop: matchout<=0, valid<=0.
//  - Latency: a word accepted in cycle N is in fill at N+1, can be popped at N+1, and
//    appears on matchout at N+2 at the earliest. Order is strict FIFO.
//  - Simultaneous accept and pop: both take effect; fill unchanged. When full, the write
//    is rejected even if a pop happens in the same cycle (no pass-through).
//    When empty, a same-cycle write is not popped.
//  - Throughput: one word per cycle in and out while link_en stays high.
//  - Pointers are AW bits and wrap modulo DEPTH. fill is tracked separately (AW+1 bits)
//    so full (fill==DEPTH) and empty (fill==0) are unambiguous.
//  - ready = (fill_next < DEPTH), registered. Upstream must not rely on it for
//    same-cycle back-pressure; rejections are counted as above.
//  - dropped_cnt saturates and never wraps; overflow clears only on reset.
//  - link_en low holds the buffer contents; the output stays at idle (0).
// STRUCTURE
//  - Shared package: MATCH_W=44, TAG_HI=43, TAG_LO=40, MATCH_IDLE=44'h0, and a
//    function is_match_valid(word) returning tag!=0. The receive memory uses the same
//    definitions.
//  - Sub-module match_tx_ram: simple dual-port RAM, DEPTH x 44, synchronous write,
//    1-cycle registered read in proc_clk. Its read output feeds matchout, gated to 0
//    with valid when no pop occurred in the previous cycle.
//  - Top level holds the pointers, fill counter, output gating and diagnostic counters.
// TESTING
//  1. After reset, write 0x1_00000000AB at cycle 0 with link_en=1 -> matchout=0x1_00000000AB
//     and valid=1 at cycle 2 only; matchout=0 at cycles 0, 1 and 3.
//  2. Write match_in=0x0_FFFFFFFFFF -> not stored; fill stays 0; dropped_cnt=1;
//     overflow=0; valid stays 0.
//  3. link_en=0: write 64 distinct tagged words -> fill=64, ready=0. Write a 65th ->
//     dropped_cnt=1, overflow=1. Then raise link_en -> 64 words out in order on
//     consecutive cycles, then idle.
//  4. When full, write and pop in the same cycle -> write rejected, fill=63,
//     overflow=1.
//  5. Continuous streaming for 200 cycles with link_en=1 and pointers wrapping three
//     times -> output sequence equals input sequence delayed 2 cycles; fill<=1 throughout.
//  6. Assert reset with fill=10 -> next cycle fill=0, matchout=0, valid=0, counters=0;
//     a new word written afterwards emerges at +2 cycles.

Source files
------------

// File: rtl/match_send_memory_pkg.sv
// Shared definitions for the match-record link (transmit and receive ends).
// A match record is 44 bits: [43:40] tag, [39:0] payload. A zero tag means
// "no record", so an all-zero word is the idle pattern on the link.
package match_send_memory_pkg;

    localparam int MATCH_W = 44;
    localparam int TAG_HI  = 43;
    localparam int TAG_LO  = 40;

    localparam logic [MATCH_W-1:0] MATCH_IDLE = 44'h0;

    // A word is a real record only when its tag is non-zero.
    function automatic logic is_match_valid(input logic [MATCH_W-1:0] word);
        return (word[TAG_HI:TAG_LO] != 4'h0);
    endfunction

endpackage

// File: rtl/match_send_memory_if.sv
// Handshake bundle between the match calculator, the transmit buffer and the link.
//   match_in / match_wr : record and write strobe from the producer
//   ready               : buffer not full (registered, advisory only)
//   link_en             : downstream accepts a word this cycle
//   matchout / valid    : link word and its qualifier (0 / 0 when idle)
// master = producer/link side, slave = transmit buffer.
interface match_send_memory_if;
    import match_send_memory_pkg::*;

    logic [MATCH_W-1:0] match_in;
    logic               match_wr;
    logic               ready;
    logic               link_en;
    logic [MATCH_W-1:0] matchout;
    logic               valid;

    modport master (
        output match_in, match_wr, link_en,
        input  ready, matchout, valid
    );

    modport slave (
        input  match_in, match_wr, link_en,
        output ready, matchout, valid
    );

endinterface

// File: rtl/match_send_memory_tx_ram.sv
// Simple dual-port storage for the match transmit buffer.
//   proc_clk, reset : clock and synchronous active-high reset (read register only)
//   we, waddr, wdata: synchronous write port
//   re, raddr, rdata: 1-cycle registered read; rdata returns MATCH_IDLE when re
//                     was low, so the register directly forms the idle-gated link word.
module match_tx_ram
    import match_send_memory_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic               proc_clk,
    input  logic               reset,
    input  logic               we,
    input  logic [AW-1:0]      waddr,
    input  logic [MATCH_W-1:0] wdata,
    input  logic               re,
    input  logic [AW-1:0]      raddr,
    output logic [MATCH_W-1:0] rdata
);

    logic [MATCH_W-1:0] mem_r [DEPTH];
    logic [MATCH_W-1:0] rdata_r;

    // Storage array write; contents are not reset, only ever read after being written.
    always_ff @(posedge proc_clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    // Registered read, forced to idle on cycles without a read so no stale word leaks out.
    always_ff @(posedge proc_clk) begin
        if (reset) begin
            rdata_r <= MATCH_IDLE;
        end else if (re) begin
            rdata_r <= mem_r[raddr];
        end else begin
            rdata_r <= MATCH_IDLE;
        end
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/match_send_memory.sv
// Transmit end of the match-record link: buffers tagged records from the match
// calculator and drives them onto the link in strict FIFO order.
//   proc_clk, reset : sole clock, synchronous active-high reset
//   bus (slave)     : match_in/match_wr in, link_en in, ready/matchout/valid out
//   fill            : occupancy 0..DEPTH
//   dropped_cnt     : saturating count of rejected writes (zero tag or full)
//   overflow        : sticky, set by any write arriving while full
module match_send_memory
    import match_send_memory_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int AW    = 6,
    parameter int CNT_W = 16
) (
    input  logic               proc_clk,
    input  logic               reset,
    match_send_memory_if.slave bus,
    output logic [AW:0]        fill,
    output logic [CNT_W-1:0]   dropped_cnt,
    output logic               overflow
);

    localparam logic [AW:0]      DEPTH_L  = (AW+1)'(DEPTH);
    localparam logic [AW:0]      FILL_ONE = (AW+1)'(1);
    localparam logic [AW-1:0]    PTR_ONE  = AW'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    logic [AW-1:0]      wr_ptr_r;
    logic [AW-1:0]      rd_ptr_r;
    logic [AW:0]        fill_r;
    logic               ready_r;
    logic               valid_r;
    logic [CNT_W-1:0]   dropped_r;
    logic               overflow_r;

    logic               full_s;
    logic               accept_s;
    logic               reject_s;
    logic               pop_s;
    logic [AW:0]        fill_next_s;
    logic [MATCH_W-1:0] rd_data_s;

    // Accept/pop decisions use the occupancy at the start of the cycle, so a write
    // into an empty buffer is never popped in the same cycle and a full buffer
    // rejects a write even when a pop frees a slot.
    always_comb begin
        full_s   = (fill_r == DEPTH_L);
        accept_s = bus.match_wr && is_match_valid(bus.match_in) && !full_s;
        reject_s = bus.match_wr && !accept_s;
        pop_s    = bus.link_en && (fill_r != {(AW+1){1'b0}});
        case ({accept_s, pop_s})
            2'b10:   fill_next_s = fill_r + FILL_ONE;
            2'b01:   fill_next_s = fill_r - FILL_ONE;
            default: fill_next_s = fill_r;
        endcase
    end

    // Pointers, occupancy, output qualifier and diagnostics.
    always_ff @(posedge proc_clk) begin
        if (reset) begin
            wr_ptr_r   <= {AW{1'b0}};
            rd_ptr_r   <= {AW{1'b0}};
            fill_r     <= {(AW+1){1'b0}};
            ready_r    <= 1'b1;
            valid_r    <= 1'b0;
            dropped_r  <= {CNT_W{1'b0}};
            overflow_r <= 1'b0;
        end else begin
            if (accept_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            fill_r  <= fill_next_s;
            ready_r <= (fill_next_s < DEPTH_L);
            valid_r <= pop_s;
            if (reject_s && (dropped_r != CNT_MAX)) begin
                dropped_r <= dropped_r + CNT_ONE;
            end
            if (bus.match_wr && full_s) begin
                overflow_r <= 1'b1;
            end
        end
    end

    match_tx_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .proc_clk (proc_clk),
        .reset    (reset),
        .we       (accept_s),
        .waddr    (wr_ptr_r),
        .wdata    (bus.match_in),
        .re       (pop_s),
        .raddr    (rd_ptr_r),
        .rdata    (rd_data_s)
    );

    assign bus.matchout = rd_data_s;
    assign bus.valid    = valid_r;
    assign bus.ready    = ready_r;
    assign fill         = fill_r;
    assign dropped_cnt  = dropped_r;
    assign overflow     = overflow_r;

endmodule
